// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN_DEF-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN_DEF-1:0] INT_MIN    = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] r_in,
  input  logic [XLEN-1:0] q_in,
  input  logic [XLEN-1:0] d_in,
  output logic [XLEN-1:0] r_out,
  output logic [XLEN-1:0] q_out
);

  logic        [XLEN:0] shifted;
  logic signed [XLEN:0] trial;

  always_comb begin
    shifted = {r_in, q_in[XLEN-1]};
    // R < D before the shift, so the difference always fits; the top bit is the borrow.
    trial   = $signed(shifted - {1'b0, d_in});
    if (trial[XLEN]) begin
      r_out = shifted[XLEN-1:0];
      q_out = {q_in[XLEN-2:0], 1'b0};
    end else begin
      r_out = trial[XLEN-1:0];
      q_out = {q_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready on both sides.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and divide-by-one in one cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE      = XLEN'(1);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   r_q, r_d, q_q, q_d, d_q, d_d;
  logic              neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic [XLEN-1:0]   step_r, step_q;
  logic              op_neg_a, op_neg_b, is_zero, is_ovf, is_one, is_special;

  div_step #(.XLEN(XLEN)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (step_r),
    .q_out (step_q)
  );

  always_comb begin
    op_neg_a   = is_signed & dividend[XLEN-1];
    op_neg_b   = is_signed & divisor[XLEN-1];
    is_zero    = (divisor == '0);
    is_ovf     = is_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
    is_one     = (divisor == ONE);
    is_special = is_zero | is_ovf | is_one;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    spec_d  = spec_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          cnt_d   = CNT_W'(XLEN);
          r_d     = '0;
          q_d     = cond_neg(dividend, op_neg_a);
          d_d     = cond_neg(divisor, op_neg_b);
          neg_q_d = op_neg_a ^ op_neg_b;
          neg_r_d = op_neg_a;
          spec_d  = is_special;
          dbz_d   = is_zero;
          // Special cases are resolved at accept; the datapath result is ignored for them.
          if (is_special) begin
            quo_d = is_zero ? ALL_ONES : dividend;
            rem_d = is_zero ? dividend : '0;
`ifdef DIV_EARLY_OUT_EN
            state_d = DONE;
`endif
          end
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (!spec_q) begin
            quo_d = cond_neg(q_q, neg_q_q);
            rem_d = cond_neg(r_q, neg_r_q);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      spec_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    r_q     <= r_d;
    q_q     <= q_d;
    d_q     <= d_d;
    neg_q_q <= neg_q_d;
    neg_r_q <= neg_r_d;
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
